// File: rtl/pipe_collector.sv
// pipe_collector: reassembles 64-bit column vectors into a WORDS x WIDTH word buffer
// and streams the words out one per handshake, in word order.
// Optional feature: define PIPE_COLLECTOR_PARITY_EN to add column parity checking
// (col_parity, par_err) and an even-parity bit on the output word (out_parity).
module pipe_collector #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             col_valid,
    output logic             col_ready,
    input  logic [4:0]       col_idx,
    input  logic [WORDS-1:0] col_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_idx,
    output logic [WIDTH-1:0] out_word,
    output logic             done,
`ifdef PIPE_COLLECTOR_PARITY_EN
    input  logic             col_parity,
    output logic             out_parity,
    output logic             par_err,
`endif
    output logic             idx_err
);

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    state_e                        state_q, state_d;
    logic [WORDS-1:0][WIDTH-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]              mask_q, mask_d;
    logic [5:0]                    out_idx_q, out_idx_d;
    logic                          done_q, done_d;
    logic                          idx_err_q, idx_err_d;
`ifdef PIPE_COLLECTOR_PARITY_EN
    logic                          par_err_q, par_err_d;
`endif

    logic col_accept;
    logic idx_ok;

    assign col_accept = col_valid & col_ready;
    assign idx_ok     = (col_idx < 5'(WIDTH));

    // Next-state: column writes while collecting, word index advance while draining.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        mask_d    = mask_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        idx_err_d = idx_err_q;
`ifdef PIPE_COLLECTOR_PARITY_EN
        par_err_d = par_err_q;
`endif
        unique case (state_q)
            StCollect: begin
                if (col_accept) begin
                    if (idx_ok) begin
                        // Column num maps to bit WIDTH-1-num of every word.
                        for (int n = 0; n < int'(WORDS); n++) begin
                            buf_d[n][5'(WIDTH-1) - col_idx] = col_data[n];
                        end
                        mask_d[col_idx] = 1'b1;
                    end else begin
                        idx_err_d = 1'b1;
                    end
`ifdef PIPE_COLLECTOR_PARITY_EN
                    if (col_parity != (^col_data)) begin
                        par_err_d = 1'b1;
                    end
`endif
                end
                if ((&mask_d) || flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (out_idx_q == 6'(WORDS-1)) begin
                        state_d   = StCollect;
                        buf_d     = '0;
                        mask_d    = '0;
                        out_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + 6'd1;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCollect;
            buf_q     <= '0;
            mask_q    <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
            idx_err_q <= 1'b0;
`ifdef PIPE_COLLECTOR_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            mask_q    <= mask_d;
            out_idx_q <= out_idx_d;
            done_q    <= done_d;
            idx_err_q <= idx_err_d;
`ifdef PIPE_COLLECTOR_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign col_ready = (state_q == StCollect);
    assign out_valid = (state_q == StDrain);
    assign out_idx   = out_idx_q;
    assign out_word  = buf_q[out_idx_q];
    assign done      = done_q;
    assign idx_err   = idx_err_q;
`ifdef PIPE_COLLECTOR_PARITY_EN
    assign out_parity = ^out_word;
    assign par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_pipe_collector.sv
// Directed self-checking bench for pipe_collector.
module tb_pipe_collector;

    localparam int WORDS = 64;
    localparam int WIDTH = 25;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             col_valid = 1'b0;
    logic             col_ready;
    logic [4:0]       col_idx = '0;
    logic [WORDS-1:0] col_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [5:0]       out_idx;
    logic [WIDTH-1:0] out_word;
    logic             done;
    logic             idx_err;
`ifdef PIPE_COLLECTOR_PARITY_EN
    logic             col_parity;
    logic             out_parity;
    logic             par_err;
    assign col_parity = ^col_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [WIDTH-1:0] exp_w [WORDS];

    always #5 clk = ~clk;

    pipe_collector #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_idx   (col_idx),
        .col_data  (col_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_word  (out_word),
        .done      (done),
`ifdef PIPE_COLLECTOR_PARITY_EN
        .col_parity(col_parity),
        .out_parity(out_parity),
        .par_err   (par_err),
`endif
        .idx_err   (idx_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one column (optionally with flush) for exactly one accepting edge.
    task automatic send_col(input int idx, input logic [WORDS-1:0] data, input bit fl);
        col_valid = 1'b1;
        col_idx   = 5'(idx);
        col_data  = data;
        flush     = fl;
        @(posedge clk); #1;
        col_valid = 1'b0;
        flush     = 1'b0;
        col_data  = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input string tag);
        int cnt = 0;
        int cyc = 0;
        bit fire;
        while (cnt < WORDS && cyc < 1000) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_colrdy"}, 64'(col_ready), 64'd0);
            check_eq({tag, "_done"}, 64'(done), 64'd0);
            check_eq({tag, "_idx"}, 64'(out_idx), 64'(cnt));
            check_eq({tag, "_word"}, 64'(out_word), 64'(exp_w[cnt]));
            fire = out_valid && out_ready;
            @(posedge clk); #1;
            if (fire) cnt++;
            cyc++;
        end
        out_ready = 1'b0;
        check_eq({tag, "_handshakes"}, 64'(cnt), 64'(WORDS));
        if (mode == 0) check_eq({tag, "_cycles"}, 64'(cyc), 64'(WORDS));
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd1);
        check_eq({tag, "_end_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_end_colrdy"}, 64'(col_ready), 64'd1);
        check_eq({tag, "_end_idx"}, 64'(out_idx), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    task automatic fill_exp(input logic [WIDTH-1:0] w);
        for (int n = 0; n < WORDS; n++) exp_w[n] = w;
    endtask

    // Word n carries n[k] at bit 24-k for k<6.
    task automatic fill_exp_pattern();
        for (int n = 0; n < WORDS; n++) begin
            exp_w[n] = '0;
            for (int k = 0; k < 6; k++) exp_w[n][24-k] = n[k];
        end
    endtask

    task automatic load_pattern_reverse();
        logic [WORDS-1:0] d;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            d = '0;
            if (k < 6) for (int n = 0; n < WORDS; n++) d[n] = n[k];
            send_col(k, d, 1'b0);
        end
    endtask

    task automatic load_full_col0();
        for (int k = 0; k < WIDTH; k++) send_col(k, (k == 0) ? {WORDS{1'b1}} : '0, 1'b0);
    endtask

    initial begin
        int budget;
        #12;
        check_eq("rst_colrdy", 64'(col_ready), 64'd1);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_idxerr", 64'(idx_err), 64'd0);
        check_eq("rst_idx", 64'(out_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full load, free-running drain; also first-word latency.
        load_full_col0();
        check_eq("t1_latency_valid", 64'(out_valid), 64'd1);
        check_eq("t1_latency_idx", 64'(out_idx), 64'd0);
        fill_exp(25'h1000000);
        drain(0, "t1");

        // Pattern reassembly, columns in reverse order.
        load_pattern_reverse();
        fill_exp_pattern();
        drain(0, "t2");

        // Early flush with two columns.
        send_col(3, {WORDS{1'b1}}, 1'b0);
        send_col(10, {WORDS{1'b1}}, 1'b0);
        check_eq("t3_pre_valid", 64'(out_valid), 64'd0);
        do_flush();
        fill_exp(25'h0204000);
        drain(0, "t3");

        // Backpressure.
        load_pattern_reverse();
        fill_exp_pattern();
        drain(1, "t4");

        // Bad index and overwrite; last column arrives with flush.
        send_col(25, {WORDS{1'b1}}, 1'b0);
        check_eq("t5_idxerr", 64'(idx_err), 64'd1);
        send_col(0, {WORDS{1'b1}}, 1'b0);
        send_col(5, {WORDS{1'b1}}, 1'b0);
        send_col(5, '0, 1'b1);
        fill_exp(25'h1000000);
        drain(0, "t5");
        check_eq("t5_idxerr_sticky", 64'(idx_err), 64'd1);

        // Async reset mid-drain.
        load_full_col0();
        out_ready = 1'b1;
        budget = 0;
        while (out_idx != 6'd30 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("t6_reach30", 64'(out_idx), 64'd30);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_colrdy", 64'(col_ready), 64'd1);
        check_eq("t6_rst_done", 64'(done), 64'd0);
        check_eq("t6_rst_idxerr", 64'(idx_err), 64'd0);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("t6_post_done", 64'(done), 64'd0);
        send_col(24, {WORDS{1'b1}}, 1'b1);
        fill_exp(25'h0000001);
        drain(0, "t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_collector.md
Name: pipe_collector

Overview:
- Inverse of the bit-column reader: accepts 64-bit column vectors (bit `num` of every word, one vector per column index) and reassembles them into a 64-word x 25-bit buffer.
- Streams the reassembled words out one per handshake, in word order, for the result writer / checker.
- Sits at the output end of the bit-serial datapath.
- Column mapping matches the reader: for column index `num`, `col_data[n]` is bit (WIDTH-1-num) of word n.

Parameters:
- WORDS, 64, number of words (= column vector width).
- WIDTH, 25, bits per word (= number of columns).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- col_valid  input  1  column vector presented.
- col_ready  output  1  block can accept a column.
- col_idx  input  5  column index `num`, range 0..WIDTH-1.
- col_data  input  WORDS  column vector; bit n belongs to word n.
- flush  input  1  drain now, even if columns are missing.
- out_valid  output  1  out_word/out_idx valid.
- out_ready  input  1  downstream accepts word.
- out_idx  output  6  word index n, 0..WORDS-1.
- out_word  output  WIDTH  reassembled word n.
- done  output  1  one-cycle pulse after the last word is accepted.
- idx_err  output  1  sticky flag: col_idx >= WIDTH was seen.

Behaviour:
- Reset (async, immediate):
  - state=COLLECT, buffer all 0, column-received mask all 0, out_idx=0.
  - col_ready=1, out_valid=0, done=0, idx_err=0.
- COLLECT:
  - col_ready=1, out_valid=0.
  - Column accepted on a rising edge with col_valid&col_ready.
  - Accepted column writes bit (WIDTH-1-col_idx) of all WORDS words and sets mask[col_idx].
  - A repeated col_idx overwrites the earlier data; last write wins.
  - col_idx >= WIDTH: no write, no mask change, idx_err set until rst.
  - Go to DRAIN on the edge where the mask becomes all-ones, or on any edge with flush=1.
  - Missing columns read out as 0.
  - col_valid and flush in the same cycle: the column is written first, then the state goes to DRAIN.
- DRAIN:
  - col_ready=0; columns presented here are ignored (not lost silently: upstream must wait on col_ready).
  - First cycle in DRAIN: out_valid=1, out_idx=0.
  - out_word = buffer word out_idx, combinational from registers; stable while out_valid & !out_ready.
  - Handshake out_valid&out_ready advances out_idx by 1.
  - flush is ignored in DRAIN.
  - Downstream may hold out_ready low indefinitely; no timeout.
- Last word (out_idx=WORDS-1) accepted:
  - done=1 for the next cycle only.
  - State returns to COLLECT; buffer, mask and out_idx cleared on the same edge.
  - col_ready=1 in the done cycle.
- Latency:
  - Last column accepted at edge T -> out_valid=1 during cycle T+1.
  - With out_ready tied high, the drain takes exactly WORDS cycles; done is asserted in the cycle after the final word.
- Reset mid-DRAIN or mid-COLLECT discards all data; no done pulse.

Optional Feature:
- Macro: PIPE_COLLECTOR_PARITY_EN.
- Defined:
  - Extra output out_parity (1 bit) = XOR-reduction of out_word, even parity; valid with out_valid, 0 under reset.
  - Extra input col_parity (1 bit), checked at column acceptance against XOR of col_data.
  - A mismatch sets sticky output par_err (reset 0); the column is still written.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Full load, free-running drain:
  - Stimulus: columns 0..24 in order, col_data = 64'hFFFF_FFFF_FFFF_FFFF for idx 0 only, else 0; out_ready=1.
  - Response: 64 words, each 25'h1000000; out_idx 0..63 on consecutive cycles; done pulses once.
- Pattern reassembly:
  - Stimulus: column idx k gets col_data bit n = (n>>k)&1 for k<6, else 0; columns sent in reverse order 24..0.
  - Response: word n equals n placed at bits 24..19 bit-reversed per mapping, i.e. bit (24-k) = n[k]; checked against a model for all 64 words.
- Early flush:
  - Stimulus: columns 3 and 10 only (all-ones), then flush.
  - Response: every word = 25'h0204000 (bits 21 and 14); col_ready=0 throughout the drain.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1...
  - Response: out_word/out_idx are held while stalled; no word is skipped or duplicated; done arrives after the 64th handshake.
- Bad index and overwrite:
  - Stimulus: col_idx=25, then idx 5 twice (all-ones, then all-zeros).
  - Response: idx_err=1 and stays set; bit 19 of every word = 0.
- Async reset mid-drain:
  - Stimulus: rst pulsed at out_idx=30.
  - Response: out_valid drops immediately, col_ready=1, no done; a fresh load then drains from idx 0 with only the new data.
